// File: rtl/clk_div_monitor.sv
// Purpose : measures high/low/period of a divided clock sampled on i_clk_ref and checks it against i_exp_ratio.
// Latency : a div-clock edge is acted upon 3 i_clk_ref cycles after it changes; o_valid pulses on the closing rise.
// Backpr. : none; results are single-cycle o_valid pulses and status levels, and the consumer samples them as they come.
//
// Ports:
//   i_clk_ref    reference clock, all logic on posedge
//   i_rst_n      asynchronous active-low reset
//   i_mon_en     monitor enable; low forces IDLE
//   i_div_clk    divided clock under test, sampled as data
//   i_exp_ratio  expected divide ratio; 0/1 = bypass (stays IDLE)
//   i_clr        synchronous clear of sticky o_err
//   o_period     last measured period, saturating at 255
//   o_high       last measured high-phase length
//   o_valid      one-cycle pulse when o_period/o_high update
//   o_locked     LOCK_CNT consecutive matching periods seen
//   o_err        sticky: a completed period mismatched
//   o_stuck      no edge for TIMEOUT cycles while measuring
module clk_div_monitor #(
  parameter int unsigned LOCK_CNT = 4,
  parameter logic [8:0]  TIMEOUT  = 9'd511
) (
  input  logic       i_clk_ref,
  input  logic       i_rst_n,
  input  logic       i_mon_en,
  input  logic       i_div_clk,
  input  logic [7:0] i_exp_ratio,
  input  logic       i_clr,
  output logic [7:0] o_period,
  output logic [7:0] o_high,
  output logic       o_valid,
  output logic       o_locked,
  output logic       o_err,
  output logic       o_stuck
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_RISE = 2'd1;
  localparam logic [1:0] S_MEAS_HIGH = 2'd2;
  localparam logic [1:0] S_MEAS_LOW  = 2'd3;

  localparam logic [3:0] LOCK_MAX = 4'(LOCK_CNT);

  logic       s1_q, s2_q, s3_q;
  logic [7:0] ratio_q;
  logic [1:0] state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] high_q, high_d;
  logic [3:0] mcnt_q, mcnt_d;
  logic [7:0] period_q, period_d;
  logic [7:0] ohigh_q, ohigh_d;
  logic       valid_q, valid_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic       stuck_q, stuck_d;

  logic       rise, fall, bypass, timeout_hit, phase_ok, is_match, ratio_chg;
  logic [8:0] cnt_inc;
  logic [9:0] sum;
  logic [7:0] period_sat;
  logic [3:0] mcnt_inc;

  // s1/s2 resynchronise the foreign clock; s3 is history for edge detection.
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  assign bypass      = ~i_mon_en | (ratio_q < 8'd2);
  assign timeout_hit = (cnt_q == TIMEOUT);
  assign cnt_inc     = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;

  // cnt_q holds the low-phase length on the closing rise.
  assign sum        = {2'b00, high_q} + {1'b0, cnt_q};
  assign period_sat = (sum > 10'd255) ? 8'hFF : sum[7:0];
  // High may exceed low by one so odd ratios still match.
  assign phase_ok   = (cnt_q == {1'b0, high_q}) || ((cnt_q + 9'd1) == {1'b0, high_q});
  assign is_match   = (period_sat == ratio_q) && phase_ok;
  assign ratio_chg  = (i_exp_ratio != ratio_q);
  assign mcnt_inc   = (mcnt_q >= LOCK_MAX) ? LOCK_MAX : mcnt_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    high_d   = high_q;
    mcnt_d   = mcnt_q;
    period_d = period_q;
    ohigh_d  = ohigh_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    err_d    = err_q & ~i_clr;
    stuck_d  = stuck_q;

    if (bypass) begin
      state_d  = S_IDLE;
      cnt_d    = 9'd0;
      mcnt_d   = 4'd0;
      locked_d = 1'b0;
      stuck_d  = 1'b0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT_RISE;
          cnt_d   = 9'd0;
        end
        S_WAIT_RISE: begin
          if (rise) begin
            cnt_d   = 9'd1;
            state_d = S_MEAS_HIGH;
          end else begin
            cnt_d = 9'd0;
          end
        end
        S_MEAS_HIGH: begin
          // An edge arriving together with the timeout wins.
          if (fall) begin
            high_d  = cnt_q[7:0];
            cnt_d   = 9'd1;
            state_d = S_MEAS_LOW;
          end else if (timeout_hit) begin
            stuck_d  = 1'b1;
            locked_d = 1'b0;
            mcnt_d   = 4'd0;
            cnt_d    = 9'd0;
            state_d  = S_WAIT_RISE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin // S_MEAS_LOW
          if (rise) begin
            period_d = period_sat;
            ohigh_d  = high_q;
            valid_d  = 1'b1;
            stuck_d  = 1'b0;
            if (is_match) begin
              mcnt_d   = mcnt_inc;
              locked_d = (mcnt_inc == LOCK_MAX);
            end else begin
              mcnt_d   = 4'd0;
              locked_d = 1'b0;
              err_d    = 1'b1;
            end
            cnt_d   = 9'd1;
            state_d = S_MEAS_HIGH;
          end else if (timeout_hit) begin
            stuck_d  = 1'b1;
            locked_d = 1'b0;
            mcnt_d   = 4'd0;
            cnt_d    = 9'd0;
            state_d  = S_WAIT_RISE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
      // A new expected ratio invalidates lock history but not the sticky error.
      if (ratio_chg && (state_q != S_IDLE)) begin
        mcnt_d   = 4'd0;
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk_ref or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      ratio_q  <= 8'd0;
      state_q  <= S_IDLE;
      cnt_q    <= 9'd0;
      high_q   <= 8'd0;
      mcnt_q   <= 4'd0;
      period_q <= 8'd0;
      ohigh_q  <= 8'd0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      s1_q     <= i_div_clk;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      ratio_q  <= i_exp_ratio;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      high_q   <= high_d;
      mcnt_q   <= mcnt_d;
      period_q <= period_d;
      ohigh_q  <= ohigh_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      stuck_q  <= stuck_d;
    end
  end

  assign o_period = period_q;
  assign o_high   = ohigh_q;
  assign o_valid  = valid_q;
  assign o_locked = locked_q;
  assign o_err    = err_q;
  assign o_stuck  = stuck_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Purpose : exercises clk_div_monitor with directed and randomised divided-clock waveforms.
// Latency : expected o_valid at drive cycle of the closing rise + 3.
// Backpr. : none; every o_valid pulse is captured at the falling ref edge.
`timescale 1ns/1ps
module tb_clk_div_monitor;
  localparam int TO = 511;

  logic       i_clk_ref;
  logic       i_rst_n;
  logic       i_mon_en;
  logic       i_div_clk;
  logic [7:0] i_exp_ratio;
  logic       i_clr;
  logic [7:0] o_period;
  logic [7:0] o_high;
  logic       o_valid;
  logic       o_locked;
  logic       o_err;
  logic       o_stuck;

  clk_div_monitor #(.LOCK_CNT(4), .TIMEOUT(9'd511)) dut (
    .i_clk_ref  (i_clk_ref),
    .i_rst_n    (i_rst_n),
    .i_mon_en   (i_mon_en),
    .i_div_clk  (i_div_clk),
    .i_exp_ratio(i_exp_ratio),
    .i_clr      (i_clr),
    .o_period   (o_period),
    .o_high     (o_high),
    .o_valid    (o_valid),
    .o_locked   (o_locked),
    .o_err      (o_err),
    .o_stuck    (o_stuck)
  );

  initial begin
    i_clk_ref = 1'b0;
    forever #5 i_clk_ref = ~i_clk_ref;
  end

  int cyc;
  always @(posedge i_clk_ref) cyc <= cyc + 1;

  typedef struct {
    int t;
    int per;
    int hi;
    int lk;
    int er;
    int st;
  } rec_t;

  rec_t act_q[$];
  rec_t exp_q[$];

  always @(negedge i_clk_ref) begin
    if (i_rst_n === 1'b1 && o_valid === 1'b1)
      act_q.push_back('{t: cyc, per: int'(o_period), hi: int'(o_high),
                        lk: int'(o_locked), er: int'(o_err), st: int'(o_stuck)});
  end

  int checks;
  int failures;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Waveform-level reference: periods are rise-to-rise intervals of the driven clock.
  bit m_active;
  bit m_have_rise;
  bit m_have_fall;
  int m_rise_k;
  int m_fall_k;
  int m_last_k;
  int m_mcnt;
  int m_err;
  int m_ratio;

  task automatic model_clear();
    m_have_rise = 0;
    m_have_fall = 0;
    m_mcnt      = 0;
    m_err       = 0;
  endtask

  task automatic model_edge(input bit lvl, input int k);
    int h, l, per;
    bit match;
    if (!m_active) return;
    // A phase of 512+ cycles means the monitor declared stuck and went back to waiting.
    if (m_have_rise && (k - m_last_k) > TO) begin
      m_have_rise = 0;
      m_have_fall = 0;
      m_mcnt      = 0;
    end
    if (lvl) begin
      if (m_have_rise && m_have_fall) begin
        h     = m_fall_k - m_rise_k;
        l     = k - m_fall_k;
        per   = (h + l > 255) ? 255 : h + l;
        match = (per == m_ratio) && (h == l || h == l + 1);
        if (match) m_mcnt = (m_mcnt >= 4) ? 4 : m_mcnt + 1;
        else begin
          m_mcnt = 0;
          m_err  = 1;
        end
        exp_q.push_back('{t: k + 3, per: per, hi: h, lk: (m_mcnt == 4) ? 1 : 0, er: m_err, st: 0});
      end
      m_have_rise = 1;
      m_have_fall = 0;
      m_rise_k    = k;
      m_last_k    = k;
    end else if (m_have_rise) begin
      m_have_fall = 1;
      m_fall_k    = k;
      m_last_k    = k;
    end
  endtask

  task automatic tick();
    @(posedge i_clk_ref);
    #1;
  endtask

  task automatic drive_lvl(input bit lvl, input int len);
    tick();
    if (lvl != i_div_clk) model_edge(lvl, cyc);
    i_div_clk = lvl;
    repeat (len - 1) tick();
  endtask

  task automatic run_div(input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      drive_lvl(1'b1, h);
      drive_lvl(1'b0, l);
    end
  endtask

  task automatic set_mode(input bit en, input int r);
    tick();
    i_mon_en = 1'b0;
    repeat (3) tick();
    i_mon_en    = en;
    i_exp_ratio = 8'(r);
    m_active    = en && (r >= 2);
    m_ratio     = r;
    model_clear();
    repeat (4) tick();
  endtask

  task automatic change_ratio(input int r);
    i_exp_ratio = 8'(r);
    if (r != m_ratio) m_mcnt = 0;
    m_ratio = r;
  endtask

  task automatic drain(input string tag);
    repeat (6) tick();
    chk({tag, "_nvalid"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      chk($sformatf("%s_t%0d", tag, i),  act_q[i].t,   exp_q[i].t);
      chk($sformatf("%s_per%0d", tag, i), act_q[i].per, exp_q[i].per);
      chk($sformatf("%s_hi%0d", tag, i),  act_q[i].hi,  exp_q[i].hi);
      chk($sformatf("%s_lk%0d", tag, i),  act_q[i].lk,  exp_q[i].lk);
      chk($sformatf("%s_er%0d", tag, i),  act_q[i].er,  exp_q[i].er);
      chk($sformatf("%s_st%0d", tag, i),  act_q[i].st,  exp_q[i].st);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, o_period, 0);
    chk({tag, "_high"},   o_high,   0);
    chk({tag, "_valid"},  o_valid,  0);
    chk({tag, "_locked"}, o_locked, 0);
    chk({tag, "_err"},    o_err,    0);
    chk({tag, "_stuck"},  o_stuck,  0);
  endtask

  initial begin
    int kf;
    int r, er, n, h, l;
    checks      = 0;
    failures    = 0;
    i_rst_n     = 1'b1;
    i_mon_en    = 1'b0;
    i_div_clk   = 1'b0;
    i_exp_ratio = 8'd0;
    i_clr       = 1'b0;
    m_active    = 0;
    m_ratio     = 0;
    model_clear();
    #2 i_rst_n = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    i_rst_n = 1'b1;

    // Ratio 4, nominal duty.
    set_mode(1'b1, 4);
    run_div(2, 2, 8);
    drive_lvl(1'b1, 2);
    drive_lvl(1'b0, 4);
    drain("r4");
    chk("r4_period", o_period, 4);
    chk("r4_high",   o_high,   2);
    chk("r4_locked", o_locked, 1);
    chk("r4_err",    o_err,    0);

    // Ratio 5, then the expected ratio moves to 6.
    set_mode(1'b1, 5);
    run_div(3, 2, 6);
    drive_lvl(1'b1, 3);
    drive_lvl(1'b0, 1);
    chk("r5_period", o_period, 5);
    chk("r5_high",   o_high,   3);
    chk("r5_locked", o_locked, 1);
    change_ratio(6);
    drive_lvl(1'b0, 1);
    chk("chg_unlock", o_locked, 0);
    chk("chg_no_err", o_err,    0);
    run_div(3, 2, 3);
    drive_lvl(1'b1, 3);
    drive_lvl(1'b0, 10);
    drain("r5to6");
    chk("err_sticky", o_err, 1);
    tick();
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    chk("err_clr", o_err, 0);
    m_err = 0;

    // Ratio 255 plus saturating and lopsided long periods.
    set_mode(1'b1, 255);
    run_div(128, 127, 4);
    drive_lvl(1'b1, 128);
    chk("r255_period", o_period, 255);
    chk("r255_high",   o_high,   128);
    chk("r255_stuck",  o_stuck,  0);
    drive_lvl(1'b0, 127);
    run_div(150, 150, 1);
    run_div(200, 100, 1);
    drive_lvl(1'b1, 5);
    drive_lvl(1'b0, 10);
    drain("r255");

    // Lock, then hold the clock low until stuck, then restart.
    set_mode(1'b1, 4);
    run_div(2, 2, 6);
    drive_lvl(1'b1, 2);
    drive_lvl(1'b0, 1);
    kf = cyc;
    while (cyc < kf + 3 + TO - 1) tick();
    chk("stuck_early",  o_stuck,  0);
    chk("stuck_prelk",  o_locked, 1);
    tick();
    chk("stuck_set",    o_stuck,  1);
    chk("stuck_unlock", o_locked, 0);
    repeat (20) tick();
    run_div(2, 2, 6);
    drive_lvl(1'b1, 2);
    drive_lvl(1'b0, 8);
    drain("stuck");
    chk("stuck_cleared", o_stuck,  0);
    chk("relocked",      o_locked, 1);

    // Bypass ratio and disabled monitor.
    set_mode(1'b1, 1);
    run_div(2, 2, 10);
    chk("byp_nvalid", act_q.size(), 0);
    chk("byp_locked", o_locked, 0);
    chk("byp_err",    o_err,    0);
    chk("byp_stuck",  o_stuck,  0);
    act_q.delete();
    exp_q.delete();
    set_mode(1'b0, 4);
    run_div(2, 2, 10);
    chk("dis_nvalid", act_q.size(), 0);
    chk("dis_locked", o_locked, 0);
    chk("dis_err",    o_err,    0);
    chk("dis_stuck",  o_stuck,  0);
    act_q.delete();
    exp_q.delete();

    // Reset asserted during the low phase.
    set_mode(1'b1, 4);
    run_div(2, 2, 5);
    drive_lvl(1'b1, 2);
    drive_lvl(1'b0, 1);
    repeat (6) tick();
    @(negedge i_clk_ref);
    #2 i_rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_clear();
    repeat (2) tick();
    i_rst_n = 1'b1;
    repeat (8) tick();
    run_div(2, 2, 6);
    drive_lvl(1'b1, 2);
    drive_lvl(1'b0, 8);
    drain("rst");

    // Randomised ratios with occasional duty or ratio errors.
    for (int s = 0; s < 6; s++) begin
      r  = $urandom_range(2, 24);
      er = ($urandom_range(0, 3) == 0) ? r + 1 : r;
      set_mode(1'b1, er);
      n = $urandom_range(3, 10);
      for (int p = 0; p < n; p++) begin
        h = (r + 1) / 2;
        l = r / 2;
        if ($urandom_range(0, 4) == 0) begin
          if ($urandom_range(0, 1) == 1) h = h + 1;
          else if (l > 1) l = l - 1;
          else h = h + 2;
        end
        drive_lvl(1'b1, h);
        drive_lvl(1'b0, l);
      end
      drive_lvl(1'b1, 2);
      drive_lvl(1'b0, 8);
      drain($sformatf("rnd%0d", s));
    end

    set_mode(1'b0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
